// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer toward the memory stage, BEQ/BNE
// resolution with a registered one-cycle PC redirect, and wrong-path slot discard.
module ex_mem_stage #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [D_WIDTH-1:0] ex_aluout,
    input  logic               ex_eq,
    input  logic [D_WIDTH-1:0] ex_wdata,
    input  logic [D_WIDTH-1:0] ex_pc,
    input  logic [D_WIDTH-1:0] ex_imm,
    input  logic [4:0]         ex_rd,
    input  logic               ex_regwrite,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic               ex_branch,
    input  logic               ex_bne,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [D_WIDTH-1:0] mem_aluout,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic [4:0]         mem_rd,
    output logic               mem_regwrite,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               redirect_valid,
    output logic [D_WIDTH-1:0] redirect_pc
);

    typedef struct packed {
        logic [D_WIDTH-1:0] aluout;
        logic [D_WIDTH-1:0] wdata;
        logic [4:0]         rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
    } entry_t;

    entry_t             head_q, head_d;
    entry_t             skid_q, skid_d;
    entry_t             in_entry;
    logic               head_valid_q, head_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [D_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic accept;
    logic live;
    logic buf_write;
    logic taken_br;
    logic pop;

    // Handshake: an entry transfers when ex_valid & ex_ready; ex_ready depends only
    // on the skid flop. The head transfers out when mem_valid & mem_ready.
    assign ex_ready  = ~skid_valid_q;
    assign accept    = ex_valid & ex_ready;
    // The slot right after a taken branch is wrong-path and is swallowed.
    assign live      = accept & ~flush & ~redirect_valid_q;
    assign buf_write = live & ~ex_branch;
    assign taken_br  = live & ex_branch & (ex_bne ^ ex_eq);
    assign pop       = head_valid_q & mem_ready;

    always_comb begin
        in_entry.aluout   = ex_aluout;
        in_entry.wdata    = ex_wdata;
        in_entry.rd       = ex_rd;
        in_entry.regwrite = ex_regwrite;
        in_entry.memread  = ex_memread;
        in_entry.memwrite = ex_memwrite;
    end

    always_comb begin
        head_d           = head_q;
        skid_d           = skid_q;
        head_valid_d     = head_valid_q;
        skid_valid_d     = skid_valid_q;
        redirect_valid_d = taken_br;
        redirect_pc_d    = redirect_pc_q;

        if (taken_br) begin
            redirect_pc_d = ex_pc + ex_imm;
        end

        if (skid_valid_q) begin
            // Skid full means ex_ready is low, so only draining can happen.
            if (pop) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (buf_write) begin
            if (!head_valid_q || pop) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end else if (pop) begin
            head_valid_d = 1'b0;
        end

        if (flush) begin
            head_valid_d     = 1'b0;
            skid_valid_d     = 1'b0;
            redirect_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= '0;
            skid_q           <= '0;
            head_valid_q     <= 1'b0;
            skid_valid_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            head_q           <= head_d;
            skid_q           <= skid_d;
            head_valid_q     <= head_valid_d;
            skid_valid_q     <= skid_valid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign mem_valid      = head_valid_q;
    assign mem_aluout     = head_q.aluout;
    assign mem_wdata      = head_q.wdata;
    assign mem_rd         = head_q.rd;
    assign mem_regwrite   = head_valid_q & head_q.regwrite;
    assign mem_memread    = head_valid_q & head_q.memread;
    assign mem_memwrite   = head_valid_q & head_q.memwrite;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic, checked
// against a queue-based model of the stage's FIFO and redirect rules.
module tb_ex_mem_stage;
  localparam int W  = 32;
  localparam int EW = 2 * W + 8;

  typedef struct packed {
    logic         valid;
    logic         branch;
    logic         bne;
    logic         eq;
    logic [W-1:0] aluout;
    logic [W-1:0] wdata;
    logic [W-1:0] pc;
    logic [W-1:0] imm;
    logic [4:0]   rd;
    logic         regwrite;
    logic         memread;
    logic         memwrite;
  } ex_in_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         ex_valid = 1'b0;
  logic         ex_ready;
  logic [W-1:0] ex_aluout = '0;
  logic         ex_eq = 1'b0;
  logic [W-1:0] ex_wdata = '0;
  logic [W-1:0] ex_pc = '0;
  logic [W-1:0] ex_imm = '0;
  logic [4:0]   ex_rd = '0;
  logic         ex_regwrite = 1'b0;
  logic         ex_memread = 1'b0;
  logic         ex_memwrite = 1'b0;
  logic         ex_branch = 1'b0;
  logic         ex_bne = 1'b0;
  logic         mem_valid;
  logic         mem_ready = 1'b0;
  logic [W-1:0] mem_aluout;
  logic [W-1:0] mem_wdata;
  logic [4:0]   mem_rd;
  logic         mem_regwrite;
  logic         mem_memread;
  logic         mem_memwrite;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;

  ex_mem_stage #(.D_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluout(ex_aluout), .ex_eq(ex_eq), .ex_wdata(ex_wdata),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_bne(ex_bne),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_aluout(mem_aluout), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: the stage is a 2-deep FIFO plus a one-shot redirect
  logic [EW-1:0] exp_q[$];
  logic          m_redir = 1'b0;
  logic [W-1:0]  m_redir_pc = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("mem_valid", EW'(mem_valid), EW'(exp_q.size() != 0));
    check_eq("ex_ready", EW'(ex_ready), EW'(exp_q.size() < 2));
    check_eq("redirect_valid", EW'(redirect_valid), EW'(m_redir));
    if (m_redir) check_eq("redirect_pc", EW'(redirect_pc), EW'(m_redir_pc));
    if (exp_q.size() != 0)
      check_eq("mem_entry", {mem_aluout, mem_wdata, mem_rd, mem_regwrite, mem_memread, mem_memwrite},
               exp_q[0]);
    else
      check_eq("mem_ctrl_gated", EW'({mem_regwrite, mem_memread, mem_memwrite}), EW'(0));
  endtask

  // driver: called just after a falling edge; checks, drives, updates model, ends at next falling edge
  task automatic step(input ex_in_t e, input logic fl, input logic mr);
    logic         acc;
    logic         pop;
    logic         shadow;
    logic [W-1:0] target;
    check_outputs();
    ex_valid    = e.valid;
    ex_branch   = e.branch;
    ex_bne      = e.bne;
    ex_eq       = e.eq;
    ex_aluout   = e.aluout;
    ex_wdata    = e.wdata;
    ex_pc       = e.pc;
    ex_imm      = e.imm;
    ex_rd       = e.rd;
    ex_regwrite = e.regwrite;
    ex_memread  = e.memread;
    ex_memwrite = e.memwrite;
    flush       = fl;
    mem_ready   = mr;
    acc    = e.valid && (exp_q.size() < 2);
    pop    = (exp_q.size() != 0) && mr;
    shadow = m_redir;
    if (fl) begin
      exp_q.delete();
      m_redir = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      m_redir = 1'b0;
      if (acc && !shadow) begin
        if (!e.branch)
          exp_q.push_back({e.aluout, e.wdata, e.rd, e.regwrite, e.memread, e.memwrite});
        else if (e.bne != e.eq) begin
          target     = e.pc + e.imm;
          m_redir    = 1'b1;
          m_redir_pc = target;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ex_in_t mk_alu(input logic [W-1:0] alu, input logic [4:0] rd);
    ex_in_t e = '0;
    e.valid = 1'b1; e.aluout = alu; e.wdata = ~alu; e.rd = rd; e.regwrite = 1'b1;
    return e;
  endfunction

  function automatic ex_in_t mk_br(input logic bne, input logic eq, input logic [W-1:0] pc,
                                   input logic [W-1:0] imm);
    ex_in_t e = '0;
    e.valid = 1'b1; e.branch = 1'b1; e.bne = bne; e.eq = eq; e.pc = pc; e.imm = imm;
    return e;
  endfunction

  function automatic ex_in_t mk_rand();
    ex_in_t e;
    e.valid    = ($urandom_range(0, 3) != 0);
    e.branch   = ($urandom_range(0, 4) == 0);
    e.bne      = 1'($urandom_range(0, 1));
    e.eq       = 1'($urandom_range(0, 1));
    e.aluout   = $urandom;
    e.wdata    = $urandom;
    e.pc       = $urandom;
    e.imm      = $urandom;
    e.rd       = 5'($urandom_range(0, 31));
    e.regwrite = 1'($urandom_range(0, 1));
    e.memread  = 1'($urandom_range(0, 1));
    e.memwrite = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_flags"}, EW'({mem_valid, redirect_valid, ex_ready}), EW'(3'b001));
    check_eq({tag, "_data"}, {mem_aluout, mem_wdata, mem_rd, mem_regwrite, mem_memread, mem_memwrite},
             EW'(0));
    check_eq({tag, "_rpc"}, EW'(redirect_pc), EW'(0));
  endtask

  task automatic async_reset_mid_cycle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    ex_valid = 1'b0;
    flush    = 1'b0;
    exp_q.delete();
    m_redir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  ex_in_t idle;

  initial begin
    idle = '0;
    #12 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // stream of four ALU entries with the sink always ready
    for (int i = 1; i <= 4; i++) step(mk_alu(32'(i * 16), 5'(i)), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(idle, 1'b0, 1'b1);

    // back-pressure: A to head, B to skid, C held until the skid drains
    step(mk_alu(32'hA, 5'd10), 1'b0, 1'b0);
    step(mk_alu(32'hB, 5'd11), 1'b0, 1'b0);
    step(mk_alu(32'hC, 5'd12), 1'b0, 1'b0);
    step(mk_alu(32'hC, 5'd12), 1'b0, 1'b1);
    step(mk_alu(32'hC, 5'd12), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b1);

    // taken BEQ, then an entry in the shadow slot, then BNE with eq=1
    step(mk_br(1'b0, 1'b1, 32'h100, 32'h20), 1'b0, 1'b1);
    check_eq("beq_target", EW'(redirect_pc), EW'(32'h120));
    step(mk_alu(32'hDEAD, 5'd7), 1'b0, 1'b1);
    step(mk_br(1'b1, 1'b1, 32'h200, 32'h40), 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    // wrapping target, followed by a second taken branch in the shadow slot
    step(mk_br(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20), 1'b0, 1'b1);
    check_eq("wrap_target", EW'(redirect_pc), EW'(32'h10));
    step(mk_br(1'b0, 1'b1, 32'h300, 32'h4), 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    // flush with head and skid full, input offered in the flush cycle
    step(mk_alu(32'h11, 5'd1), 1'b0, 1'b0);
    step(mk_alu(32'h22, 5'd2), 1'b0, 1'b0);
    step(mk_alu(32'h33, 5'd3), 1'b1, 1'b0);
    step(idle, 1'b0, 1'b1);

    // flush while a redirect is pending, with a live entry in the flush cycle
    step(mk_alu(32'h44, 5'd4), 1'b0, 1'b0);
    step(mk_br(1'b0, 1'b1, 32'h400, 32'h8), 1'b0, 1'b0);
    step(mk_alu(32'h55, 5'd5), 1'b1, 1'b0);
    step(mk_alu(32'h66, 5'd6), 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    // async reset between edges, then a fresh entry
    step(mk_alu(32'h77, 5'd7), 1'b0, 1'b0);
    step(mk_alu(32'h88, 5'd8), 1'b0, 1'b0);
    async_reset_mid_cycle();
    step(mk_alu(32'h99, 5'd9), 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(mk_rand(), ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 3; i++) step(idle, 1'b0, 1'b1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage between the execute ALU and the data-memory stage of the reduced RISC-V core. It registers the ALU result, store data and writeback controls behind a 2-entry skid buffer with a valid/ready handshake. It resolves BEQ/BNE from the ALU `eq` flag and issues a one-cycle PC redirect for taken branches. It also discards the single wrong-path slot that follows a taken branch.

## Interface
- `D_WIDTH`, 32: datapath width (ALU result, store data, PC, immediate)
- `clk`  in  1: single clock, rising edge
- `rst_n`  in  1: asynchronous, active-low reset
- `flush`  in  1: synchronous kill of all held and incoming state
- `ex_valid`  in  1: execute-side entry valid
- `ex_ready`  out  1: stage can accept an entry this cycle
- `ex_aluout`  in  D_WIDTH: ALU result (address or writeback value)
- `ex_eq`  in  1: ALU equality flag
- `ex_wdata`  in  D_WIDTH: store data (register operand 2)
- `ex_pc`, `ex_imm`  in  D_WIDTH each: instruction PC, branch offset
- `ex_rd`  in  5: destination register
- `ex_regwrite`, `ex_memread`, `ex_memwrite`  in  1 each: writeback/load/store controls
- `ex_branch`, `ex_bne`  in  1 each: instruction is a branch; branch is BNE (else BEQ)
- `mem_valid`  out  1: head entry valid
- `mem_ready`  in  1: memory stage consumes head entry
- `mem_aluout`, `mem_wdata`  out  D_WIDTH each; `mem_rd`  out  5; `mem_regwrite`, `mem_memread`, `mem_memwrite`  out  1 each
- `redirect_valid`  out  1: taken-branch pulse
- `redirect_pc`  out  D_WIDTH: branch target

## Operation
- Accept when `ex_valid & ex_ready`. `ex_ready = ~skid_valid`, registered state only, with no combinational path from `mem_ready`.
- Buffer: head register drives `mem_*`; skid register holds overflow.
  - Head pops on `mem_valid & mem_ready`.
  - An accepted entry goes to head if head is empty or popping and skid is empty. Otherwise it goes to skid.
  - When head pops and skid is valid, skid moves to head.
  - Order is strictly FIFO.
- Branches (`ex_branch=1`) never occupy a slot.
  - `taken = ex_bne ^ ex_eq`.
  - On an accepted taken branch: next cycle `redirect_valid=1` and `redirect_pc = ex_pc + ex_imm`, truncated mod 2^D_WIDTH. Both are registered.
  - A not-taken branch is accepted and dropped with no effect.
- Shadow slot: while `redirect_valid=1`, `ex_ready` still follows the rule above. Any entry accepted that cycle is discarded, with no buffer write and no redirect, even if it is itself a branch.
- Flush has highest priority: `flush=1` clears head valid, skid valid and the pending redirect register. Any entry presented that cycle is discarded. Data fields need not clear.
- `mem_*` data is stable while `mem_valid & ~mem_ready`.
- `mem_regwrite`/`mem_memread`/`mem_memwrite` are gated with `mem_valid` (0 when empty).
- At most one of `mem_memread`/`mem_memwrite` is expected. If both are set, both are passed unchanged.

## Timing
- Reset (`rst_n=0`, async):
  - `mem_valid=0`, `redirect_valid=0`, `ex_ready=1`.
  - All `mem_*` data, `mem_rd` and `redirect_pc` = 0; skid cleared.
- Latency: accept at cycle N → `mem_valid=1` at N+1 when the buffer was empty or head was popping.
- Throughput: 1 entry/cycle with `mem_ready=1` continuously.
- Back-pressure: after `mem_ready` drops, the stage absorbs exactly one more entry (into skid). `ex_ready=0` from the following cycle. With `mem_ready=1`, `ex_ready` returns to 1 the cycle after skid drains into head.
- Taken branch accepted at N → `redirect_valid=1` at N+1 only. Entry accepted at N+1 is discarded.
- Two taken branches cannot produce back-to-back pulses: the second lands in the shadow slot.
- `flush` at N → `mem_valid=0` and `redirect_valid=0` at N+1. Accepts resume normally at N+1.
- Reset asserted mid-operation: all outputs reach reset values immediately. The first accept is possible in the first clock edge after release.

## Test plan
- Stream: 4 ALU entries (aluout 0x10,0x20,0x30,0x40, rd 1..4) with `mem_ready=1` → `mem_valid` from cycle 1, same order, 1/cycle, `ex_ready` stays 1.
- Back-pressure: `mem_ready=0` with 3 offered entries → head=A, skid=B, `ex_ready=0`, C held. `mem_ready=1` → A, B, C delivered in order, no loss or duplication.
- BEQ, `eq=1`, pc 0x100, imm 0x20 → one-cycle pulse with `redirect_pc=0x120`, no `mem_valid`. The entry accepted in the pulse cycle is dropped. BNE with `eq=1` → no pulse.
- Wrap: pc 0xFFFFFFF0, imm 0x20, taken → `redirect_pc=0x00000010`.
- Flush with head and skid full and a pending redirect → next cycle `mem_valid=0`, `redirect_valid=0`, `ex_ready=1`. The flush-cycle input is never seen.
- Async reset asserted mid-stream between clock edges → outputs zero immediately. After release, a fresh entry appears at `mem_*` 1 cycle after accept.
